input_port_unit: RTL and testbench

- Per-input-port front end of the 3-port router: a flit FIFO plus XY route computation with wormhole route hold.
- Sits directly upstream of the switch allocator.
- Presents each buffered flit with a 3-bit output-port request (`EMPTY / `OUT_LOCAL_PORT / `OUT_X1_PORT / `OUT_Y1_PORT from global.v) and an update strobe.
- Pops the head flit when the downstream crossbar grants it.

---
 rtl/input_port_unit.sv | 187 ++++++++++++++++++
 tb/tb_input_port_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_unit.sv
// Per-input-port router front end: flit FIFO, XY route computation and wormhole route hold.
// Optional INPORT_ERR_CNT_EN adds err_cnt, a saturating count of orphan flits dropped while idle.

`ifndef EMPTY
`define EMPTY 3'b000
`endif
`ifndef OUT_LOCAL_PORT
`define OUT_LOCAL_PORT 3'b001
`endif
`ifndef OUT_X1_PORT
`define OUT_X1_PORT 3'b010
`endif
`ifndef OUT_Y1_PORT
`define OUT_Y1_PORT 3'b100
`endif

module input_port_unit #(
    parameter int unsigned FLIT_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned XW     = 1,
    parameter int unsigned YW     = 2,
    parameter int unsigned X_ID   = 0,
    parameter int unsigned Y_ID   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_W-1:0]        in_flit,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [FLIT_W-1:0]        out_flit,
    output logic [2:0]               out_dst,
    output logic                     out_dst_en,
    input  logic                     grant,
`ifdef INPORT_ERR_CNT_EN
    output logic [7:0]               err_cnt,
`endif
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned HEAD_B = FLIT_W - 1;
    localparam int unsigned TAIL_B = FLIT_W - 2;
    localparam int unsigned DST_W  = XW + YW;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_e;

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_e            state_q, state_d;
    logic [2:0]        route_q, route_d;
    logic [2:0]        dst_prev_q;
    logic              pop_prev_q;

    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              pop_grant;
    logic              drop;
    logic [FLIT_W-1:0] head_flit;

    // XY dimension-order routing: resolve x first, then y, then eject locally
    function automatic logic [2:0] route_xy(input logic [DST_W-1:0] dest);
        logic [XW-1:0] dx;
        logic [YW-1:0] dy;
        dx = dest[DST_W-1:YW];
        dy = dest[YW-1:0];
        if (dx != XW'(X_ID)) begin
            return `OUT_X1_PORT;
        end else if (dy != YW'(Y_ID)) begin
            return `OUT_Y1_PORT;
        end
        return `OUT_LOCAL_PORT;
    endfunction

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign in_ready  = !full && !rst;
    assign push      = in_valid && in_ready;
    assign head_flit = mem_q[rd_ptr_q];
    assign out_flit  = head_flit;
    assign fifo_cnt  = cnt_q;

    // Request only while a packet route is held and a flit is actually buffered
    assign out_dst   = (state_q == S_ACTIVE && !empty) ? route_q : `EMPTY;
    assign pop_grant = grant && (out_dst != `EMPTY);
    assign drop      = (state_q == S_IDLE) && !empty && !head_flit[HEAD_B];
    assign pop       = pop_grant || drop;

    // Re-latch strobe: request changed, or a new flit arrived behind the same route
    assign out_dst_en = (out_dst != dst_prev_q) || (pop_prev_q && (out_dst != `EMPTY));

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        case (state_q)
            S_IDLE: begin
                if (!empty && head_flit[HEAD_B]) begin
                    route_d = route_xy(head_flit[DST_W-1:0]);
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (pop_grant && head_flit[TAIL_B]) begin
                    route_d = `EMPTY;
                    state_d = S_IDLE;
                end
            end
            default: begin
                route_d = `EMPTY;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            route_q    <= `EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            dst_prev_q <= `EMPTY;
            pop_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            route_q    <= route_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            dst_prev_q <= out_dst;
            pop_prev_q <= pop_grant;
        end
    end

    // Flit storage carries no reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_flit;
        end
    end

`ifdef INPORT_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (drop && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_input_port_unit.sv
// Directed self-checking bench for input_port_unit (X_ID=0, Y_ID=0, DEPTH=4).
// Build with INPORT_ERR_CNT_EN defined to also exercise the orphan drop counter.

module tb_input_port_unit;

    localparam logic [2:0] D_EMPTY = 3'b000;
    localparam logic [2:0] D_LOCAL = 3'b001;
    localparam logic [2:0] D_X1    = 3'b010;
    localparam logic [2:0] D_Y1    = 3'b100;

    logic        clk;
    logic        rst;
    logic [31:0] in_flit;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_flit;
    logic [2:0]  out_dst;
    logic        out_dst_en;
    logic        grant;
    logic [2:0]  fifo_cnt;
`ifdef INPORT_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int checks;
    int errors;

    input_port_unit #(
        .FLIT_W(32), .DEPTH(4), .XW(1), .YW(2), .X_ID(0), .Y_ID(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_dst   (out_dst),
        .out_dst_en(out_dst_en),
        .grant     (grant),
`ifdef INPORT_ERR_CNT_EN
        .err_cnt   (err_cnt),
`endif
        .fifo_cnt  (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic h, input logic t, input logic [7:0] tag,
                                       input logic x, input logic [1:0] y);
        return {h, t, 19'd0, tag, x, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        grant = 1'b0;
        in_flit = '0;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_during_rst got=%0b exp=0", in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_dst !== D_EMPTY) begin
                errors++;
                $display("FAIL reset_out_dst cyc=%0d got=%0d exp=%0d", i, out_dst, D_EMPTY);
            end
            checks++;
            if (out_dst_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_dst_en cyc=%0d got=%0b exp=0", i, out_dst_en);
            end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready cyc=%0d got=%0b exp=1", i, in_ready);
            end
            checks++;
            if (fifo_cnt !== 3'd0) begin
                errors++;
                $display("FAIL reset_fifo_cnt cyc=%0d got=%0d exp=0", i, fifo_cnt);
            end
            tick();
        end
    endtask

    task automatic test_single_flit();
        logic [31:0] f;
        f = mk(1'b1, 1'b1, 8'hA5, 1'b1, 2'd2);
        in_flit = f;
        in_valid = 1'b1;
        grant = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (fifo_cnt !== 3'd1 || out_dst !== D_EMPTY) begin
            errors++;
            $display("FAIL single_after_push cnt=%0d dst=%0d exp cnt=1 dst=%0d", fifo_cnt, out_dst, D_EMPTY);
        end
        tick();
        checks++;
        if (out_dst !== D_X1 || out_dst_en !== 1'b1) begin
            errors++;
            $display("FAIL single_request dst=%0d en=%0b exp dst=%0d en=1", out_dst, out_dst_en, D_X1);
        end
        checks++;
        if (out_flit !== f) begin
            errors++;
            $display("FAIL single_out_flit got=%h exp=%h", out_flit, f);
        end
        tick();
        checks++;
        if (out_dst !== D_EMPTY || out_dst_en !== 1'b1 || fifo_cnt !== 3'd0) begin
            errors++;
            $display("FAIL single_popped dst=%0d en=%0b cnt=%0d exp dst=0 en=1 cnt=0", out_dst, out_dst_en, fifo_cnt);
        end
        tick();
        checks++;
        if (out_dst_en !== 1'b0) begin
            errors++;
            $display("FAIL single_en_settle got=%0b exp=0", out_dst_en);
        end
        grant = 1'b0;
    endtask

    task automatic test_four_flit();
        logic [31:0] pk [4];
        for (int i = 0; i < 4; i++) begin
            pk[i] = mk(i == 0, i == 3, 8'(8'h10 + i), 1'b0, 2'd3);
        end
        grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_flit = pk[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (fifo_cnt !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL four_full cnt=%0d ready=%0b exp cnt=4 ready=0", fifo_cnt, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_dst !== D_Y1 || out_dst_en !== 1'b0 || out_flit !== pk[0]) begin
                errors++;
                $display("FAIL four_steady cyc=%0d dst=%0d en=%0b flit=%h exp dst=%0d en=0 flit=%h",
                         i, out_dst, out_dst_en, out_flit, D_Y1, pk[0]);
            end
            tick();
        end
        grant = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (out_dst_en !== 1'b1) begin
                errors++;
                $display("FAIL four_pop_strobe pop=%0d got=%0b exp=1", k, out_dst_en);
            end
            if (k < 3) begin
                checks++;
                if (out_dst !== D_Y1 || fifo_cnt !== 3'(3 - k) || out_flit !== pk[k + 1]) begin
                    errors++;
                    $display("FAIL four_pop pop=%0d dst=%0d cnt=%0d flit=%h exp dst=%0d cnt=%0d flit=%h",
                             k, out_dst, fifo_cnt, out_flit, D_Y1, 3 - k, pk[k + 1]);
                end
            end else begin
                checks++;
                if (out_dst !== D_EMPTY || fifo_cnt !== 3'd0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL four_tail dst=%0d cnt=%0d ready=%0b exp dst=0 cnt=0 ready=1",
                             out_dst, fifo_cnt, in_ready);
                end
            end
        end
        grant = 1'b0;
        tick();
        checks++;
        if (out_dst_en !== 1'b0 || out_dst !== D_EMPTY) begin
            errors++;
            $display("FAIL four_idle en=%0b dst=%0d exp en=0 dst=0", out_dst_en, out_dst);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pk  [4];
        logic [2:0]  exp [7];
        pk[0] = mk(1'b1, 1'b0, 8'h20, 1'b0, 2'd0);
        pk[1] = mk(1'b0, 1'b1, 8'h21, 1'b0, 2'd0);
        pk[2] = mk(1'b1, 1'b0, 8'h30, 1'b1, 2'd0);
        pk[3] = mk(1'b0, 1'b1, 8'h31, 1'b1, 2'd0);
        exp[0] = D_EMPTY; exp[1] = D_LOCAL; exp[2] = D_LOCAL; exp[3] = D_EMPTY;
        exp[4] = D_X1;    exp[5] = D_X1;    exp[6] = D_EMPTY;
        grant = 1'b1;
        for (int s = 0; s < 7; s++) begin
            if (s < 4) begin
                in_flit = pk[s];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            checks++;
            if (out_dst !== exp[s]) begin
                errors++;
                $display("FAIL b2b_dst step=%0d got=%0d exp=%0d", s, out_dst, exp[s]);
            end
        end
        checks++;
        if (fifo_cnt !== 3'd0) begin
            errors++;
            $display("FAIL b2b_drained cnt=%0d exp=0", fifo_cnt);
        end
        grant = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_orphan();
        grant = 1'b0;
        in_flit = mk(1'b0, 1'b0, 8'h44, 1'b1, 2'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (fifo_cnt !== 3'd1 || out_dst !== D_EMPTY) begin
            errors++;
            $display("FAIL orphan_buffered cnt=%0d dst=%0d exp cnt=1 dst=0", fifo_cnt, out_dst);
        end
        tick();
        checks++;
        if (fifo_cnt !== 3'd0 || out_dst !== D_EMPTY || out_dst_en !== 1'b0) begin
            errors++;
            $display("FAIL orphan_dropped cnt=%0d dst=%0d en=%0b exp cnt=0 dst=0 en=0",
                     fifo_cnt, out_dst, out_dst_en);
        end
`ifdef INPORT_ERR_CNT_EN
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL orphan_err_cnt got=%0d exp=1", err_cnt);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_flit = mk(1'b0, i[0], 8'(i), 1'b0, 2'(i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (err_cnt !== 8'd255 || fifo_cnt !== 3'd0) begin
            errors++;
            $display("FAIL orphan_err_sat err=%0d cnt=%0d exp err=255 cnt=0", err_cnt, fifo_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_packet();
        grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_flit = mk(i == 0, 1'b0, 8'(8'h50 + i), 1'b0, 2'd3);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (fifo_cnt !== 3'd3 || out_dst !== D_Y1) begin
            errors++;
            $display("FAIL midrst_before cnt=%0d dst=%0d exp cnt=3 dst=%0d", fifo_cnt, out_dst, D_Y1);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready_in_rst got=%0b exp=0", in_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (fifo_cnt !== 3'd0 || out_dst !== D_EMPTY || out_dst_en !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_after cnt=%0d dst=%0d en=%0b ready=%0b exp cnt=0 dst=0 en=0 ready=1",
                     fifo_cnt, out_dst, out_dst_en, in_ready);
        end
        in_flit = mk(1'b0, 1'b0, 8'h60, 1'b0, 2'd3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (fifo_cnt !== 3'd1 || out_dst !== D_EMPTY) begin
            errors++;
            $display("FAIL midrst_body_buffered cnt=%0d dst=%0d exp cnt=1 dst=0", fifo_cnt, out_dst);
        end
        tick();
        checks++;
        if (fifo_cnt !== 3'd0 || out_dst !== D_EMPTY) begin
            errors++;
            $display("FAIL midrst_body_dropped cnt=%0d dst=%0d exp cnt=0 dst=0", fifo_cnt, out_dst);
        end
`ifdef INPORT_ERR_CNT_EN
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL midrst_err_cnt got=%0d exp=1", err_cnt);
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_flit = '0;
        grant = 1'b0;
        test_reset();
        test_single_flit();
        test_four_flit();
        test_back_to_back();
        test_orphan();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
